// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Produces E-stage operand forwarding selects, stall/flush enables for the
// pipeline registers, a data-memory wait FSM with timeout trap, and a
// saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int MAX_WAIT      = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [ADDRESS_WIDTH-1:0] RdE,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [ADDRESS_WIDTH-1:0] RdW,
  input  logic [1:0]               ResultSrcE,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     PCSrcE,
  input  logic                     MemAccessM,
  input  logic                     MemReadyM,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushW,
  output logic                     MemErr,
  output logic [CNT_WIDTH-1:0]     StallCount
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t                 state_q,     state_d;
  logic [WCNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
  logic                   mem_err_q,   mem_err_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic                   lw_stall_s;
  logic                   mem_stall_s;
  logic                   stall_f_s;

  // Select the freshest in-flight producer for one E-stage source; M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDRESS_WIDTH-1:0] rs,
    input logic [ADDRESS_WIDTH-1:0] rd_m,
    input logic                     we_m,
    input logic [ADDRESS_WIDTH-1:0] rd_w,
    input logic                     we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != {ADDRESS_WIDTH{1'b0}}) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != {ADDRESS_WIDTH{1'b0}}) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects; held at RD1E/RD2E while the controller is in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (CLR) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

  // Hazard terms: a load in E feeding D, and a data-memory access that has not completed.
  always_comb begin
    lw_stall_s  = 1'b0;
    mem_stall_s = 1'b0;
    if ((ResultSrcE == 2'b01) && (RdE != {ADDRESS_WIDTH{1'b0}}) &&
        ((RdE == Rs1D) || (RdE == Rs2D))) begin
      lw_stall_s = 1'b1;
    end else begin
      lw_stall_s = 1'b0;
    end
    case (state_q)
      ST_RUN:  mem_stall_s = MemAccessM && !MemReadyM;
      ST_WAIT: mem_stall_s = !MemReadyM;
      ST_ERR:  mem_stall_s = 1'b1;
      default: mem_stall_s = 1'b1;
    endcase
  end

  // Stall/flush enables; a memory wait freezes everything and defers any redirect.
  always_comb begin
    stall_f_s = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (CLR) begin
      stall_f_s = 1'b0;
    end else if (mem_stall_s) begin
      stall_f_s = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      FlushW    = 1'b1;
    end else begin
      stall_f_s = lw_stall_s;
      StallD    = lw_stall_s;
      FlushD    = PCSrcE;
      FlushE    = lw_stall_s || PCSrcE;
    end
  end

  assign StallF     = stall_f_s;
  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

  // Memory-wait sequencing: count wait cycles and trap into the terminal error state on timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (MemAccessM && !MemReadyM) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else begin
          state_d    = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          state_d    = ST_RUN;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else if (wait_cnt_q == WCNT_W'(MAX_WAIT)) begin
          state_d    = ST_ERR;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d   = ST_ERR;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d   = ST_ERR;
        mem_err_d = 1'b1;
      end
    endcase
  end

  // Stall performance counter: one more at every PC-hold cycle, pinned at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f_s && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; CLR abandons any wait without raising the error.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WCNT_W{1'b0}};
      mem_err_q   <= 1'b0;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Drives two controller builds (default and a small wait/counter build) with
// directed and randomized stimulus, checking every cycle against a
// behavioural model of pending-access length, error trap and stall count.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, MemReadyM;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, me0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, me1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int errors = 0;
  int checks = 0;

  // model state per build: 0 = MAX_WAIT 16 / 16-bit count, 1 = MAX_WAIT 4 / 4-bit count
  int m_pend [2];
  int m_err  [2];
  int m_cnt  [2];
  int m_maxw [2];
  int m_cmax [2];

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.ADDRESS_WIDTH(5), .MAX_WAIT(16), .CNT_WIDTH(16)) dut0 (
    .CLK(CLK), .CLR(CLR), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .StallM(sm0), .FlushD(fd0), .FlushE(fe0), .FlushW(fw0), .MemErr(me0),
    .StallCount(cnt0));

  pipeline_hazard_ctrl #(.ADDRESS_WIDTH(5), .MAX_WAIT(4), .CNT_WIDTH(4)) dut1 (
    .CLK(CLK), .CLR(CLR), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .StallM(sm1), .FlushD(fd1), .FlushE(fe1), .FlushW(fw1), .MemErr(me1),
    .StallCount(cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'd2;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_memstall(input int i);
    if (m_err[i] != 0) return 1'b1;
    if (m_pend[i] == 0) return MemAccessM && !MemReadyM;
    return !MemReadyM;
  endfunction

  // packed {FA,FB,SF,SD,SE,SM,FD,FE,FW,MemErr}
  function automatic logic [11:0] m_out(input int i);
    bit lw, ms, pc;
    logic [11:0] o;
    if (CLR) return 12'd0;
    lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    ms = m_memstall(i);
    pc = PCSrcE;
    o[11:10] = m_fwd(Rs1E);
    o[9:8]   = m_fwd(Rs2E);
    if (ms) o[7:1] = 7'b1111001;
    else    o[7:1] = {lw, lw, 1'b0, 1'b0, pc, lw | pc, 1'b0};
    o[0] = (m_err[i] != 0);
    return o;
  endfunction

  task automatic compare_all();
    chk("outs0", {fa0, fb0, sf0, sd0, se0, sm0, fd0, fe0, fw0, me0}, m_out(0));
    chk("outs1", {fa1, fb1, sf1, sd1, se1, sm1, fd1, fe1, fw1, me1}, m_out(1));
    chk("count0", cnt0, CLR ? 0 : m_cnt[0]);
    chk("count1", cnt1, CLR ? 0 : m_cnt[1]);
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (CLR) begin
        m_pend[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      end else begin
        logic [11:0] o;
        bit ms;
        o  = m_out(i);
        ms = m_memstall(i);
        if (o[7] && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
        if (m_err[i] == 0) begin
          if (ms) begin
            if (m_pend[i] == m_maxw[i]) m_err[i] = 1;
            else m_pend[i]++;
          end else begin
            m_pend[i] = 0;
          end
        end
      end
    end
  endtask

  // settle after driving at negedge, compare, then advance the model past the coming edge
  task automatic step();
    #1;
    compare_all();
    model_update();
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b1;
  endtask

  int rdy_pct;

  initial begin
    m_maxw[0] = 16; m_cmax[0] = 65535;
    m_maxw[1] = 4;  m_cmax[1] = 15;
    for (int i = 0; i < 2; i++) begin m_pend[i] = 0; m_err[i] = 0; m_cnt[i] = 0; end

    // reset: hazard-provoking inputs must still yield all-zero outputs
    idle();
    CLR = 1'b1;
    PCSrcE = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    nxt();
    step();
    chk("rst_fwdA", fa0, 2'b00);
    chk("rst_flush", {fd0, fe0, sf0, sd0}, 4'b0000);
    chk("rst_count", cnt0, 16'd0);
    nxt();
    CLR = 1'b0;
    idle();

    // forwarding priority and x0
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    step(); chk("fwd_M", fa0, 2'b10); nxt();
    RdM = 5'd0;
    step(); chk("fwd_W", fa0, 2'b01); nxt();
    Rs1E = 5'd0;
    step(); chk("fwd_x0", fa0, 2'b00); nxt();
    idle();

    // load-use stall
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    step(); chk("lw_stall", {sf0, sd0, fe0, fd0}, 4'b1110); nxt();
    idle();
    step(); chk("lw_count", cnt0, 16'd1); chk("lw_release", sf0, 1'b0); nxt();

    // redirect, then redirect with load-use
    PCSrcE = 1'b1;
    step(); chk("br_flush", {fd0, fe0, sf0}, 3'b110); nxt();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    step(); chk("br_lw", {sf0, sd0, fd0, fe0}, 4'b1111); nxt();
    idle();

    // three-cycle memory wait with a held redirect
    MemAccessM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mw_stall", {sf0, sd0, se0, sm0, fw0, fd0, fe0}, 7'b1111100);
      nxt();
    end
    MemReadyM = 1'b1;
    step(); chk("mw_ready", {sf0, sm0, fd0, fe0}, 4'b0011); nxt();
    idle();
    step(); chk("mw_count", cnt0, 16'd5); nxt();

    // timeout trap: one RUN cycle plus 16 WAIT cycles
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int k = 0; k < 16; k++) begin step(); nxt(); end
    step(); chk("to_noerr", me0, 1'b0); nxt();
    MemAccessM = 1'b0; MemReadyM = 1'b1;
    step(); chk("to_err", {me0, sf0, sm0, fw0}, 4'b1111); nxt();
    step(); chk("to_sticky", {me0, sf0}, 2'b11); nxt();
    CLR = 1'b1;
    step(); chk("to_clr", {me0, sf0, sm0, fw0}, 4'b0000); chk("to_clr_cnt", cnt0, 16'd0); nxt();
    CLR = 1'b0;
    step(); chk("to_run", {me0, sf0}, 2'b00); nxt();

    // small counter saturation
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    for (int k = 0; k < 20; k++) begin step(); nxt(); end
    idle();
    step(); chk("sat_small", cnt1, 4'hF); chk("sat_big", cnt0, 16'd20); nxt();

    // randomized traffic
    rdy_pct = 60;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 90;
          1: rdy_pct = 50;
          default: rdy_pct = 15;
        endcase
      end
      CLR        = ($urandom_range(0, 99) < 2);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 99) < 20);
      MemAccessM = ($urandom_range(0, 99) < 35);
      MemReadyM  = ($urandom_range(0, 99) < rdy_pct);
      step();
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
